topk_stream_accum: RTL and testbench

- Downstream consumer of the 8-input bitonic backend.
- Takes one fully sorted DATALENGTH-wide vector per handshake beat and keeps a running top-K bank across a multi-beat frame.
- On the frame's last beat it presents the frame's K largest values, sorted, on a valid/ready output port.
- Turns the per-vector sorter into a streaming top-K engine.

---
 rtl/topk_stream_accum_if.sv | 42 ++++
 rtl/topk_stream_accum.sv | 228 ++++++++++++++++++++++
 tb/tb_topk_stream_accum.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/topk_stream_accum_if.sv
// Handshake bundle for topk_stream_accum: sorted-vector input beats and a
// top-K result port. The design side uses the slave modport and the producer
// or consumer side uses master.
// Optional macro TOPK_ACC_INDEX_EN adds the idx_o origin-tag vector.
interface topk_stream_accum_if #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 8,
  parameter int K          = 8,
  parameter int CNTWIDTH   = 16
`ifdef TOPK_ACC_INDEX_EN
  ,
  parameter int IDXWIDTH   = 16
`endif
);
  logic                                 in_valid_i;
  logic                                 in_ready_o;
  logic                                 in_last_i;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_i;
  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [K-1:0][DATAWIDTH-1:0]          y_o;
  logic [CNTWIDTH-1:0]                  beats_o;
`ifdef TOPK_ACC_INDEX_EN
  logic [K-1:0][IDXWIDTH-1:0]           idx_o;
`endif

  modport slave (
    input  in_valid_i, in_last_i, x_i, out_ready_i,
    output in_ready_o, out_valid_o, y_o, beats_o
`ifdef TOPK_ACC_INDEX_EN
    , output idx_o
`endif
  );

  modport master (
    output in_valid_i, in_last_i, x_i, out_ready_i,
    input  in_ready_o, out_valid_o, y_o, beats_o
`ifdef TOPK_ACC_INDEX_EN
    , input idx_o
`endif
  );
endinterface

// File: rtl/topk_stream_accum.sv
// Streaming top-K accumulator. It takes one descending-sorted vector per beat
// and keeps the K largest values seen in the frame. On the last beat it
// presents them, sorted, on the output port.
// Optional macro TOPK_ACC_INDEX_EN carries per-element origin tags
// (beat-1)*DATALENGTH+lane alongside the values and reports them on idx_o.

// Merge-rank lane: the output position of one candidate equals its own index
// in its sorted source plus the number of entries in the other sorted source
// that must order ahead of it. STRICT=1 means only strictly larger entries
// win, which is used for bank entries because a bank entry wins ties.
module topk_stream_accum_rank #(
  parameter int N         = 8,
  parameter int DATAWIDTH = 8,
  parameter int RW        = 5,
  parameter int BASE      = 0,
  parameter bit STRICT    = 1'b1
) (
  input  logic [DATAWIDTH-1:0]        cand_i,
  input  logic [N-1:0][DATAWIDTH-1:0] vec_i,
  output logic [RW-1:0]               rank_o
);
  // Count the other-side entries that order ahead of this candidate.
  always_comb begin
    rank_o = RW'(BASE);
    for (int i = 0; i < N; i++) begin
      if (STRICT ? (vec_i[i] > cand_i) : (vec_i[i] >= cand_i))
        rank_o = rank_o + RW'(1);
    end
  end
endmodule

module topk_stream_accum #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 8,
  parameter int K          = 8,
  parameter int CNTWIDTH   = 16
`ifdef TOPK_ACC_INDEX_EN
  ,
  parameter int IDXWIDTH   = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  topk_stream_accum_if.slave bus
);
  // Largest possible rank is K-1+DATALENGTH.
  localparam int RW = $clog2(K + DATALENGTH + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;
  logic   in_ready, out_valid, accept, load;

  logic [K-1:0][DATAWIDTH-1:0] bank_q, bank_d, merged;
  logic [CNTWIDTH-1:0]         beats_q, beats_d;
  logic [K-1:0][DATAWIDTH-1:0] y_q;
  logic [CNTWIDTH-1:0]         beats_out_q;

  logic [K-1:0][RW-1:0]          rank_b;
  logic [DATALENGTH-1:0][RW-1:0] rank_x;

`ifdef TOPK_ACC_INDEX_EN
  logic [K-1:0][IDXWIDTH-1:0]          tag_q, tag_d, merged_tag;
  logic [DATALENGTH-1:0][IDXWIDTH-1:0] x_tag;
  logic [IDXWIDTH-1:0]                 tag_base_q, tag_base_d;
  logic [K-1:0][IDXWIDTH-1:0]          idx_q;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.y_o         = y_q;
  assign bus.beats_o     = beats_out_q;
`ifdef TOPK_ACC_INDEX_EN
  assign bus.idx_o       = idx_q;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode. DONE blocks input until the result drains.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = bus.in_valid_i;
        load     = bus.in_valid_i;
        if (bus.in_valid_i) state_d = bus.in_last_i ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        accept   = bus.in_valid_i;
        if (bus.in_valid_i && bus.in_last_i) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane merge ranks: bank entries against the incoming vector, and
  // incoming entries against the bank.
  for (genvar i = 0; i < K; i++) begin : g_bank_rank
    topk_stream_accum_rank #(
      .N(DATALENGTH), .DATAWIDTH(DATAWIDTH), .RW(RW), .BASE(i), .STRICT(1'b1)
    ) u_rank (
      .cand_i(bank_q[i]), .vec_i(bus.x_i), .rank_o(rank_b[i])
    );
  end

  for (genvar l = 0; l < DATALENGTH; l++) begin : g_in_rank
    topk_stream_accum_rank #(
      .N(K), .DATAWIDTH(DATAWIDTH), .RW(RW), .BASE(l), .STRICT(1'b0)
    ) u_rank (
      .cand_i(bus.x_i[l]), .vec_i(bank_q), .rank_o(rank_x[l])
    );
  end

`ifdef TOPK_ACC_INDEX_EN
  // Incoming tags: the first beat starts at 0, and later beats offset by the running base.
  always_comb begin
    x_tag = '0;
    for (int l = 0; l < DATALENGTH; l++)
      x_tag[l] = (state_q == IDLE) ? IDXWIDTH'(l) : tag_base_q + IDXWIDTH'(l);
  end
`endif

  // Output position j takes whichever candidate landed on rank j. The ranks are
  // unique for sorted inputs, so ranks K and above simply fall off the bank.
  always_comb begin
    merged = '0;
`ifdef TOPK_ACC_INDEX_EN
    merged_tag = '0;
`endif
    for (int j = 0; j < K; j++) begin
      for (int i = 0; i < K; i++) begin
        if (rank_b[i] == RW'(j)) begin
          merged[j] = bank_q[i];
`ifdef TOPK_ACC_INDEX_EN
          merged_tag[j] = tag_q[i];
`endif
        end
      end
      for (int l = 0; l < DATALENGTH; l++) begin
        if (rank_x[l] == RW'(j)) begin
          merged[j] = bus.x_i[l];
`ifdef TOPK_ACC_INDEX_EN
          merged_tag[j] = x_tag[l];
`endif
        end
      end
    end
  end

  // Bank and beat-count next state. The first beat overwrites the bank, later
  // beats merge into it, and the count saturates at all-ones.
  always_comb begin
    bank_d  = bank_q;
    beats_d = beats_q;
`ifdef TOPK_ACC_INDEX_EN
    tag_d      = tag_q;
    tag_base_d = tag_base_q;
`endif
    if (accept) begin
      if (load) begin
        bank_d  = bus.x_i[K-1:0];
        beats_d = CNTWIDTH'(1);
`ifdef TOPK_ACC_INDEX_EN
        tag_d      = x_tag[K-1:0];
        tag_base_d = IDXWIDTH'(DATALENGTH);
`endif
      end else begin
        bank_d  = merged;
        beats_d = (&beats_q) ? beats_q : beats_q + CNTWIDTH'(1);
`ifdef TOPK_ACC_INDEX_EN
        tag_d      = merged_tag;
        tag_base_d = tag_base_q + IDXWIDTH'(DATALENGTH);
`endif
      end
    end
  end

  // Working bank registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q  <= '0;
      beats_q <= '0;
`ifdef TOPK_ACC_INDEX_EN
      tag_q      <= '0;
      tag_base_q <= '0;
`endif
    end else begin
      bank_q  <= bank_d;
      beats_q <= beats_d;
`ifdef TOPK_ACC_INDEX_EN
      tag_q      <= tag_d;
      tag_base_q <= tag_base_d;
`endif
    end
  end

  // Result registers: captured on the last accepted beat and held until the
  // next frame completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q         <= '0;
      beats_out_q <= '0;
`ifdef TOPK_ACC_INDEX_EN
      idx_q       <= '0;
`endif
    end else if (accept && bus.in_last_i) begin
      y_q         <= bank_d;
      beats_out_q <= beats_d;
`ifdef TOPK_ACC_INDEX_EN
      idx_q       <= tag_d;
`endif
    end
  end
endmodule

// File: tb/tb_topk_stream_accum.sv
// Bench for topk_stream_accum. It covers the table-driven frames from the test
// plan, hand sequences for backpressure, mid-frame reset and counter
// saturation, and randomized frames checked against a sort-based reference.
module tb_topk_stream_accum;
  localparam int DW = 8, DL = 8, K = 8, CW = 16, CW2 = 4;

  typedef logic [DL-1:0][DW-1:0] vec_t;
  typedef logic [K-1:0][DW-1:0]  res_t;
  typedef logic [K-1:0][15:0]    idxv_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  topk_stream_accum_if #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .CNTWIDTH(CW))  bus();
  topk_stream_accum_if #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .CNTWIDTH(CW2)) bus2();

  topk_stream_accum #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .CNTWIDTH(CW))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  topk_stream_accum #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .CNTWIDTH(CW2))
    dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    vec_t v;
    v[0] = DW'(a0); v[1] = DW'(a1); v[2] = DW'(a2); v[3] = DW'(a3);
    v[4] = DW'(a4); v[5] = DW'(a5); v[6] = DW'(a6); v[7] = DW'(a7);
    return v;
  endfunction

  function automatic idxv_t mki(input int a0, a1, a2, a3, a4, a5, a6, a7);
    idxv_t v;
    v[0] = 16'(a0); v[1] = 16'(a1); v[2] = 16'(a2); v[3] = 16'(a3);
    v[4] = 16'(a4); v[5] = 16'(a5); v[6] = 16'(a6); v[7] = 16'(a7);
    return v;
  endfunction

  function automatic vec_t rand_vec(input int maxv);
    int a[DL];
    int t;
    vec_t v;
    for (int i = 0; i < DL; i++) a[i] = int'($urandom_range(0, maxv));
    for (int i = 1; i < DL; i++)
      for (int j = i; j > 0 && a[j] > a[j-1]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    for (int i = 0; i < DL; i++) v[i] = DW'(a[i]);
    return v;
  endfunction

  // Reference: every element of the frame, tagged with its arrival order. The
  // frame's top-K is the first K after a stable descending sort by value.
  typedef struct { int v; int o; } el_t;
  el_t fr[$];
  int  fr_beats;

  function automatic void model_clear();
    fr.delete();
    fr_beats = 0;
  endfunction

  function automatic void model_push(input vec_t x);
    for (int l = 0; l < DL; l++) fr.push_back('{v: int'(x[l]), o: fr_beats * DL + l});
    fr_beats++;
  endfunction

  function automatic void model_top(output res_t y, output idxv_t idx);
    bit used[];
    int best;
    used = new[fr.size()];
    y = '0; idx = '0;
    for (int j = 0; j < K; j++) begin
      best = -1;
      for (int e = 0; e < fr.size(); e++)
        if (!used[e] && (best < 0 || fr[e].v > fr[best].v ||
                         (fr[e].v == fr[best].v && fr[e].o < fr[best].o)))
          best = e;
      used[best] = 1'b1;
      y[j]   = DW'(fr[best].v);
      idx[j] = 16'(fr[best].o);
    end
  endfunction

  // Present one beat and hold it until the DUT accepts it.
  task automatic send(input vec_t x, input bit last);
    int t = 0;
    bus.in_valid_i = 1'b1; bus.x_i = x; bus.in_last_i = last;
    while (!bus.in_ready_o && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.in_ready_o) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.in_last_i = 1'b0; bus.x_i = rand_vec(255);
  endtask

  // Check the presented result, then drain it after an optional stall.
  task automatic check_result(input string nm, input res_t y, input int beats,
                              input idxv_t idx, input int stall);
    chk({nm, "_out_valid"}, 256'(bus.out_valid_o), 256'(1));
    chk({nm, "_in_ready"},  256'(bus.in_ready_o),  256'(0));
    chk({nm, "_y"},         256'(bus.y_o),         256'(y));
    chk({nm, "_beats"},     256'(bus.beats_o),     256'(beats));
`ifdef TOPK_ACC_INDEX_EN
    chk({nm, "_idx"},       256'(bus.idx_o),       256'(idx));
`else
    if (idx != idx) $display("unreachable");
`endif
    for (int s = 0; s < stall; s++) begin @(posedge clk); #1; end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk({nm, "_drained"}, 256'(bus.out_valid_o), 256'(0));
  endtask

  typedef struct {
    string name;
    int    nb;
    vec_t  x0, x1;
    res_t  y;
    int    beats;
    idxv_t idx;
  } rec_t;

  initial begin
    rec_t  tbl[4];
    res_t  ey, hold_y;
    idxv_t eidx;
    vec_t  v;
    int    nb, bps;

    rst = 1'b1;
    bus.in_valid_i = 0; bus.in_last_i = 0; bus.x_i = '0; bus.out_ready_i = 0;
    bus2.in_valid_i = 0; bus2.in_last_i = 0; bus2.x_i = '0; bus2.out_ready_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready",  256'(bus.in_ready_o),  256'(1));
    chk("rst_out_valid", 256'(bus.out_valid_o), 256'(0));
    chk("rst_y",         256'(bus.y_o),         256'(0));
    chk("rst_beats",     256'(bus.beats_o),     256'(0));
`ifdef TOPK_ACC_INDEX_EN
    chk("rst_idx",       256'(bus.idx_o),       256'(0));
`endif

    tbl[0] = '{name: "single", nb: 1, x0: mk(9,7,7,5,3,2,1,0), x1: '0,
               y: mk(9,7,7,5,3,2,1,0), beats: 1, idx: mki(0,1,2,3,4,5,6,7)};
    tbl[1] = '{name: "two_beat", nb: 2, x0: mk(50,40,30,20,10,5,4,3),
               x1: mk(45,35,25,15,1,1,0,0), y: mk(50,45,40,35,30,25,20,15),
               beats: 2, idx: mki(0,8,1,9,2,10,3,11)};
    tbl[2] = '{name: "ties", nb: 2, x0: mk(7,7,7,7,7,7,7,7), x1: mk(7,7,7,7,7,7,7,7),
               y: mk(7,7,7,7,7,7,7,7), beats: 2, idx: mki(0,1,2,3,4,5,6,7)};
    tbl[3] = '{name: "replace", nb: 2, x0: mk(10,9,8,7,6,5,4,3),
               x1: mk(100,90,80,70,60,50,40,30), y: mk(100,90,80,70,60,50,40,30),
               beats: 2, idx: mki(8,9,10,11,12,13,14,15)};

    for (int r = 0; r < 4; r++) begin
      if (tbl[r].nb == 1) send(tbl[r].x0, 1'b1);
      else begin
        send(tbl[r].x0, 1'b0);
        send(tbl[r].x1, 1'b1);
      end
      check_result(tbl[r].name, tbl[r].y, tbl[r].beats, tbl[r].idx, 0);
    end

    // Backpressure: hold DONE with a beat pending, then release.
    send(mk(9,7,7,5,3,2,1,0), 1'b1);
    hold_y = bus.y_o;
    chk("bp_first_y", 256'(hold_y), 256'(mk(9,7,7,5,3,2,1,0)));
    bus.in_valid_i = 1'b1; bus.x_i = mk(99,98,97,96,95,94,93,92); bus.in_last_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready",  256'(bus.in_ready_o),  256'(0));
      chk("bp_out_valid", 256'(bus.out_valid_o), 256'(1));
      chk("bp_y",         256'(bus.y_o),         256'(mk(9,7,7,5,3,2,1,0)));
      chk("bp_beats",     256'(bus.beats_o),     256'(1));
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk("bp_idle_ready", 256'(bus.in_ready_o),  256'(1));
    chk("bp_idle_valid", 256'(bus.out_valid_o), 256'(0));
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.in_last_i = 1'b0;
    check_result("bp_fresh", mk(99,98,97,96,95,94,93,92), 1, mki(0,1,2,3,4,5,6,7), 0);

    // Reset mid-frame discards the partial frame.
    for (int b = 0; b < 3; b++) send(mk(200,200,200,200,200,200,200,200), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 256'(bus.out_valid_o), 256'(0));
    chk("mid_rst_ready", 256'(bus.in_ready_o),  256'(1));
    chk("mid_rst_y",     256'(bus.y_o),         256'(0));
    chk("mid_rst_beats", 256'(bus.beats_o),     256'(0));
    send(mk(8,7,6,5,4,3,2,1), 1'b1);
    check_result("post_rst", mk(8,7,6,5,4,3,2,1), 1, mki(0,1,2,3,4,5,6,7), 0);

    // Saturation on the 4-bit counter instance: 21 beats report 15.
    model_clear();
    for (int b = 0; b < 21; b++) begin
      v = rand_vec(255);
      model_push(v);
      chk("sat_in_ready", 256'(bus2.in_ready_o), 256'(1));
      bus2.in_valid_i = 1'b1; bus2.x_i = v; bus2.in_last_i = (b == 20);
      @(posedge clk); #1;
    end
    bus2.in_valid_i = 1'b0; bus2.in_last_i = 1'b0;
    model_top(ey, eidx);
    chk("sat_out_valid", 256'(bus2.out_valid_o), 256'(1));
    chk("sat_beats",     256'(bus2.beats_o),     256'(15));
    chk("sat_y",         256'(bus2.y_o),         256'(ey));
`ifdef TOPK_ACC_INDEX_EN
    chk("sat_idx",       256'(bus2.idx_o),       256'(eidx));
`endif
    bus2.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready_i = 1'b0;
    chk("sat_drained", 256'(bus2.out_valid_o), 256'(0));

    // Randomized frames with idle gaps and output stalls.
    for (int f = 0; f < 40; f++) begin
      model_clear();
      nb = int'($urandom_range(1, 6));
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        v = rand_vec((f % 2 == 0) ? 15 : 255);
        model_push(v);
        send(v, b == nb - 1);
      end
      model_top(ey, eidx);
      bps = nb;
      check_result("rand", ey, bps, eidx, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
